mem_access: RTL and testbench

Memory stage of the five-stage RV32I pipeline, sitting directly downstream of the execute stage's EX-MEM register. It consumes the EX_MEM_* bundle, performs loads and stores over a request/acknowledge data bus, and formats load data with the correct lanes and sign. It registers the MEM-WB bundle for writeback and stalls the pipeline while a bus access is outstanding.

---
 rtl/rv_pkg.sv | 29 ++
 rtl/mem_access_if.sv | 16 +
 rtl/mem_align.sv | 46 ++++
 rtl/mem_access.sv | 169 ++++++++++++++++
 tb/tb_mem_access.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by the execute and memory stages:
// opcode classes, load/store size encodings and the memory-stage FSM state.
package rv_pkg;

  localparam logic [6:0] OPC_LCC  = 7'b0000011;
  localparam logic [6:0] OPC_SCC  = 7'b0100011;
  localparam logic [6:0] OPC_BCC  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  // funct3[1:0] access size; funct3[2] selects zero-extension on loads
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } mem_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = addr_lo[0];
    else if (size == SZ_WORD) mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
interface mem_access_if;
  // Request/acknowledge: the master raises DREQ and keeps DADDR/DWE/DBE/DWDATA
  // stable until a cycle in which the slave returns DACK=1; that cycle completes
  // the access and DRDATA is valid in it. DACK while DREQ=0 carries no meaning.
  logic        DREQ;
  logic [31:0] DADDR;
  logic        DWE;
  logic [3:0]  DBE;
  logic [31:0] DWDATA;
  logic        DACK;
  logic [31:0] DRDATA;

  modport master (output DREQ, DADDR, DWE, DBE, DWDATA, input DACK, DRDATA);
  modport slave  (input DREQ, DADDR, DWE, DBE, DWDATA, output DACK, DRDATA);
endinterface

// File: rtl/mem_align.sv
// Lane steering for the memory stage: byte enables, store replication,
// load extraction with sign/zero extension, and alignment check.
module mem_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
  assign misalign = is_misaligned(funct3[1:0], addr_lo);

  always_comb begin
    be    = 4'b1111;
    wdata = rs2;
    ldata = rdata;
    case (funct3[1:0])
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{rs2[7:0]}};
        ldata = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{rs2[15:0]}};
        ldata = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2;
        ldata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: drives the data bus for loads/stores, stalls while an
// access is outstanding, and registers the MEM-WB writeback bundle.
module mem_access
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESN,
  input  logic [31:0] EX_MEM_inst,
  input  logic [31:0] EX_MEM_pc,
  input  logic [31:0] EX_MEM_alu,
  input  logic [31:0] EX_MEM_rs2,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_is_load,
  input  logic        EX_MEM_is_store,
  input  logic        EX_MEM_is_jal,
  input  logic        EX_MEM_is_jalr,
  mem_access_if.master dbus,
  output logic        MEM_HLT,
  output logic [31:0] MEM_WB_inst,
  output logic [31:0] MEM_WB_pc,
  output logic [31:0] MEM_WB_data,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_wen,
  output logic        MEM_WB_misalign,
  output logic        MEM_WB_fault,
  output mem_state_t  dbg_state
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  // Loaded with TIMEOUT-1 so the counter hits zero in the TIMEOUT-th BUS cycle
  localparam logic [CW-1:0] TO_LOAD = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_op;
  logic        aligned_op;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ldata;
  logic        in_bus;
  logic        expire;
  logic        hlt;
  logic        mis_now;

  mem_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] wb_inst_q, wb_inst_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_wen_q, wb_wen_d;
  logic        wb_mis_q, wb_mis_d;
  logic        wb_fault_q, wb_fault_d;

  assign opcode     = EX_MEM_inst[6:0];
  assign funct3     = EX_MEM_inst[14:12];
  assign mem_op     = (EX_MEM_inst != 32'd0) && (EX_MEM_is_load || EX_MEM_is_store);
  assign aligned_op = mem_op && !misalign;

  mem_align u_align (
    .funct3   (funct3),
    .addr_lo  (EX_MEM_alu[1:0]),
    .rs2      (EX_MEM_rs2),
    .rdata    (dbus.DRDATA),
    .be       (be),
    .wdata    (wdata),
    .ldata    (ldata),
    .misalign (misalign)
  );

  // Bus outputs are gated by the state flop so reset clears them asynchronously;
  // operands come straight from EX_MEM, which upstream holds during the stall.
  assign in_bus      = (state_q == BUS);
  assign dbus.DREQ   = in_bus;
  assign dbus.DADDR  = in_bus ? {EX_MEM_alu[31:2], 2'b00} : 32'd0;
  assign dbus.DWE    = in_bus && EX_MEM_is_store;
  assign dbus.DBE    = in_bus ? be : 4'b0000;
  assign dbus.DWDATA = in_bus ? wdata : 32'd0;

  assign expire = in_bus && !dbus.DACK && (TIMEOUT != 0) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hlt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (aligned_op) begin
          state_d = BUS;
          cnt_d   = TO_LOAD;
          hlt     = 1'b1;
        end
      end
      BUS: begin
        if (dbus.DACK || expire) begin
          state_d = IDLE;
        end else begin
          hlt = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_inst_d  = wb_inst_q;
    wb_pc_d    = wb_pc_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_wen_d   = wb_wen_q;
    wb_mis_d   = 1'b0;
    wb_fault_d = 1'b0;
    mis_now    = (state_q == IDLE) && mem_op && misalign;
    if (!hlt) begin
      wb_inst_d  = EX_MEM_inst;
      wb_pc_d    = EX_MEM_pc;
      wb_rd_d    = EX_MEM_rd;
      wb_mis_d   = mis_now;
      wb_fault_d = expire;
      if (mis_now || expire)               wb_data_d = 32'd0;
      else if (mem_op && EX_MEM_is_load)   wb_data_d = ldata;
      else if (EX_MEM_is_jal || EX_MEM_is_jalr) wb_data_d = EX_MEM_pc + 32'd4;
      else                                 wb_data_d = EX_MEM_alu;
      wb_wen_d = (EX_MEM_rd != 5'd0) && (EX_MEM_inst != 32'd0) &&
                 (opcode != OPC_SCC) && (opcode != OPC_BCC) && !mis_now && !expire;
    end
  end

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_inst_q  <= 32'd0;
      wb_pc_q    <= 32'd0;
      wb_data_q  <= 32'd0;
      wb_rd_q    <= 5'd0;
      wb_wen_q   <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_inst_q  <= wb_inst_d;
      wb_pc_q    <= wb_pc_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_wen_q   <= wb_wen_d;
      wb_mis_q   <= wb_mis_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  assign MEM_HLT         = hlt;
  assign MEM_WB_inst     = wb_inst_q;
  assign MEM_WB_pc       = wb_pc_q;
  assign MEM_WB_data     = wb_data_q;
  assign MEM_WB_rd       = wb_rd_q;
  assign MEM_WB_wen      = wb_wen_q;
  assign MEM_WB_misalign = wb_mis_q;
  assign MEM_WB_fault    = wb_fault_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, randomized ops against a
// behavioural model, and hand-written reset/stray-acknowledge sequences.
module tb_mem_access;
  import rv_pkg::*;

  localparam int unsigned TO = 4;
  localparam int CL_NONE = 0, CL_LD = 1, CL_ST = 2, CL_JAL = 3, CL_JALR = 4;

  typedef struct {
    logic [31:0] inst, pc, alu, rs2;
    logic [4:0]  rd;
    logic        ld, st, jal, jalr;
    int          delay;
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic        wen, mis, fault;
    int          hlt, dreq;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RESN = 1'b0;
  logic [31:0] ex_inst, ex_pc, ex_alu, ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_ld, ex_st, ex_jal, ex_jalr;
  logic        mem_hlt;
  logic [31:0] wb_inst, wb_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        wb_wen, wb_mis, wb_fault;
  mem_state_t  dbg_state;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  mem_access_if dbus();

  mem_access #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESN(RESN),
    .EX_MEM_inst(ex_inst), .EX_MEM_pc(ex_pc), .EX_MEM_alu(ex_alu),
    .EX_MEM_rs2(ex_rs2), .EX_MEM_rd(ex_rd),
    .EX_MEM_is_load(ex_ld), .EX_MEM_is_store(ex_st),
    .EX_MEM_is_jal(ex_jal), .EX_MEM_is_jalr(ex_jalr),
    .dbus(dbus.master),
    .MEM_HLT(mem_hlt),
    .MEM_WB_inst(wb_inst), .MEM_WB_pc(wb_pc), .MEM_WB_data(wb_data),
    .MEM_WB_rd(wb_rd), .MEM_WB_wen(wb_wen),
    .MEM_WB_misalign(wb_mis), .MEM_WB_fault(wb_fault),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s actual=%h required=%h", tag, name, act, exp);
    end
  endtask

  function automatic op_t mk_op(logic [31:0] inst, logic [31:0] pc, logic [31:0] alu,
                                logic [31:0] rs2, logic [4:0] rd, int cls, int delay,
                                logic [31:0] rdata);
    op_t o;
    o.inst = inst; o.pc = pc; o.alu = alu; o.rs2 = rs2; o.rd = rd;
    o.ld = (cls == CL_LD); o.st = (cls == CL_ST);
    o.jal = (cls == CL_JAL); o.jalr = (cls == CL_JALR);
    o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  function automatic exp_t mk_exp(logic [31:0] data, logic wen, logic mis, logic fault,
                                  int hlt, int dreq, logic [31:0] addr, logic we,
                                  logic [3:0] be, logic [31:0] wdata);
    exp_t e;
    e.data = data; e.wen = wen; e.mis = mis; e.fault = fault;
    e.hlt = hlt; e.dreq = dreq; e.addr = addr; e.we = we; e.be = be; e.wdata = wdata;
    return e;
  endfunction

  task automatic add_vec(input op_t o, input exp_t e);
    vec_t v;
    v.op = o;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Behavioural reference: what the stage must produce for one op, from the ISA rules
  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [31:0] off, b, h, lv;
    logic        mem;
    int          size;
    f3   = o.inst[14:12];
    opc  = o.inst[6:0];
    size = int'(f3[1:0]);
    off  = o.alu % 4;
    mem  = (o.inst != 0) && (o.ld || o.st);
    e.mis = mem && ((size == 1 && (o.alu % 2) != 0) || (size == 2 && off != 0));
    e.fault = 1'b0;
    e.hlt = 0;
    e.dreq = 0;
    if (mem && !e.mis) begin
      if (TO != 0 && o.delay >= int'(TO)) begin
        e.fault = 1'b1;
        e.hlt = int'(TO);
        e.dreq = int'(TO);
      end else begin
        e.hlt = o.delay + 1;
        e.dreq = o.delay + 1;
      end
    end
    e.addr = o.alu - off;
    e.we = o.st;
    if (size == 0) begin
      e.be = 4'(1 << off);
      e.wdata = (o.rs2 & 32'hFF) * 32'h0101_0101;
      b = (o.rdata >> (8 * off)) & 32'hFF;
      lv = (!f3[2] && b >= 128) ? b - 32'd256 : b;
    end else if (size == 1) begin
      e.be = 4'(3 << (2 * (off / 2)));
      e.wdata = (o.rs2 & 32'hFFFF) * 32'h0001_0001;
      h = (o.rdata >> (16 * (off / 2))) & 32'hFFFF;
      lv = (!f3[2] && h >= 32768) ? h - 32'd65536 : h;
    end else begin
      e.be = 4'hF;
      e.wdata = o.rs2;
      lv = o.rdata;
    end
    if (e.mis || e.fault) e.data = 0;
    else if (mem && o.ld) e.data = lv;
    else if (o.jal || o.jalr) e.data = o.pc + 4;
    else e.data = o.alu;
    e.wen = (o.rd != 0) && (o.inst != 0) && (opc != OPC_SCC) && (opc != OPC_BCC) &&
            !e.mis && !e.fault;
    return e;
  endfunction

  task automatic gen_random(output op_t o);
    int kind;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  ld_f3[5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    kind = $urandom_range(0, 9);
    imm = 12'($urandom);
    rs1 = 5'($urandom);
    o = mk_op(32'd0, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 5'($urandom_range(0, 31)),
              CL_NONE, $urandom_range(0, 5), $urandom);
    if (kind <= 3) begin
      f3 = ld_f3[$urandom_range(0, 4)];
      o.inst = {imm, rs1, f3, o.rd, OPC_LCC};
      o.ld = 1'b1;
    end else if (kind <= 5) begin
      f3 = 3'($urandom_range(0, 2));
      o.inst = {imm[11:5], 5'($urandom), rs1, f3, imm[4:0], OPC_SCC};
      o.st = 1'b1;
    end else if (kind == 6) begin
      o.inst = {imm, rs1, 3'($urandom), o.rd, 7'b0110011};
    end else if (kind == 7) begin
      o.inst = {imm, rs1, 3'b000, o.rd, (imm[0] ? OPC_JAL : OPC_JALR)};
      o.jal = imm[0];
      o.jalr = !imm[0];
    end else if (kind == 8) begin
      o.inst = {imm[11:5], 5'($urandom), rs1, 3'b000, imm[4:0], OPC_BCC};
    end
    if ((o.ld || o.st) && $urandom_range(0, 1) == 1) begin
      if (o.inst[13:12] == 2'b01) o.alu = o.alu & 32'hFFFF_FFFE;
      if (o.inst[13:12] == 2'b10) o.alu = o.alu & 32'hFFFF_FFFC;
    end
  endtask

  // Driver: present one op, play the bus slave, then check the registered result
  task automatic run_op(input string tag, input op_t o, input exp_t e);
    int cyc, hlt_n, dreq_n;
    logic done, unstable, first_dreq;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    cyc = 0; hlt_n = 0; dreq_n = 0; done = 0; unstable = 0; first_dreq = 1'b1;
    s_addr = 0; s_wdata = 0; s_be = 0; s_we = 0;
    ex_inst = o.inst; ex_pc = o.pc; ex_alu = o.alu; ex_rs2 = o.rs2; ex_rd = o.rd;
    ex_ld = o.ld; ex_st = o.st; ex_jal = o.jal; ex_jalr = o.jalr;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      if (cyc == 0) first_dreq = dbus.DREQ;
      if (dbus.DREQ) begin
        dreq_n++;
        if (dreq_n == 1) begin
          s_addr = dbus.DADDR; s_we = dbus.DWE; s_be = dbus.DBE; s_wdata = dbus.DWDATA;
        end else if (dbus.DADDR !== s_addr || dbus.DWE !== s_we ||
                     dbus.DBE !== s_be || dbus.DWDATA !== s_wdata) begin
          unstable = 1'b1;
        end
        dbus.DACK = (dreq_n == o.delay + 1);
        dbus.DRDATA = dbus.DACK ? o.rdata : $urandom;
      end else begin
        dbus.DACK = 1'($urandom_range(0, 1));
        dbus.DRDATA = $urandom;
      end
      #1;
      if (mem_hlt) hlt_n++;
      else done = 1'b1;
      cyc++;
      @(posedge CLK);
      #1;
      dbus.DACK = 1'b0;
    end
    check(tag, "completes", 32'(done), 32'd1);
    check(tag, "dreq_first_cycle", 32'(first_dreq), 32'd0);
    check(tag, "hlt_cycles", 32'(hlt_n), 32'(e.hlt));
    check(tag, "dreq_cycles", 32'(dreq_n), 32'(e.dreq));
    if (e.dreq > 0) begin
      check(tag, "daddr", s_addr, e.addr);
      check(tag, "dwe", 32'(s_we), 32'(e.we));
      check(tag, "dbe", 32'(s_be), 32'(e.be));
      check(tag, "dwdata", s_wdata, e.wdata);
      check(tag, "bus_stable", 32'(unstable), 32'd0);
    end
    check(tag, "wb_data", wb_data, e.data);
    check(tag, "wb_wen", 32'(wb_wen), 32'(e.wen));
    check(tag, "wb_misalign", 32'(wb_mis), 32'(e.mis));
    check(tag, "wb_fault", 32'(wb_fault), 32'(e.fault));
    check(tag, "wb_inst", wb_inst, o.inst);
    check(tag, "wb_pc", wb_pc, o.pc);
    check(tag, "wb_rd", 32'(wb_rd), 32'(o.rd));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, "dreq", 32'(dbus.DREQ), 32'd0);
    check(tag, "daddr", dbus.DADDR, 32'd0);
    check(tag, "dwe_dbe", {27'd0, dbus.DWE, dbus.DBE}, 32'd0);
    check(tag, "dwdata", dbus.DWDATA, 32'd0);
    check(tag, "wb_inst_pc", wb_inst | wb_pc, 32'd0);
    check(tag, "wb_data", wb_data, 32'd0);
    check(tag, "wb_rd_flags", {24'd0, wb_rd, wb_wen, wb_mis, wb_fault}, 32'd0);
    check(tag, "state", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    op_t  o;
    exp_t e;
    dbus.DACK = 1'b0;
    dbus.DRDATA = 32'd0;
    // An aligned load is presented during reset: nothing may leave IDLE
    ex_inst = 32'h0000_A003; ex_pc = 32'd0; ex_alu = 32'h0000_1000; ex_rs2 = 32'hFFFF_FFFF;
    ex_rd = 5'd1; ex_ld = 1'b1; ex_st = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    check_all_zero("reset");
    ex_inst = 32'd0; ex_ld = 1'b0;
    @(posedge CLK);
    #1;
    RESN = 1'b1;

    // Directed table
    add_vec(mk_op(32'h0000_8283, 32'h000, 32'h1003, 32'h0, 5'd5, CL_LD, 0, 32'h80FF_FF00),
            mk_exp(32'hFFFF_FF80, 1, 0, 0, 1, 1, 32'h1000, 0, 4'b1000, 32'h0));
    add_vec(mk_op(32'h0020_9023, 32'h004, 32'h2002, 32'h1234_ABCD, 5'd0, CL_ST, 1, 32'h0),
            mk_exp(32'h2002, 0, 0, 0, 2, 2, 32'h2000, 1, 4'b1100, 32'hABCD_ABCD));
    add_vec(mk_op(32'h0000_A303, 32'h008, 32'h3001, 32'h0, 5'd6, CL_LD, 0, 32'h0),
            mk_exp(32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 4'b0000, 32'h0));
    add_vec(mk_op(32'h0020_81B3, 32'h00C, 32'h1234, 32'h0, 5'd3, CL_NONE, 0, 32'h0),
            mk_exp(32'h1234, 1, 0, 0, 0, 0, 32'h0, 0, 4'b0000, 32'h0));
    add_vec(mk_op(32'h0000_D383, 32'h010, 32'h4002, 32'h0, 5'd7, CL_LD, 3, 32'h8001_0000),
            mk_exp(32'h0000_8001, 1, 0, 0, 4, 4, 32'h4000, 0, 4'b1100, 32'h0));
    add_vec(mk_op(32'h0000_A403, 32'h014, 32'h5000, 32'h0, 5'd8, CL_LD, 99, 32'h0),
            mk_exp(32'h0, 0, 0, 1, 4, 4, 32'h5000, 0, 4'b1111, 32'h0));
    add_vec(mk_op(32'h0080_00EF, 32'h100, 32'h0108, 32'h0, 5'd1, CL_JAL, 0, 32'h0),
            mk_exp(32'h104, 1, 0, 0, 0, 0, 32'h0, 0, 4'b0000, 32'h0));
    add_vec(mk_op(32'h0020_8463, 32'h104, 32'h0001, 32'h0, 5'd8, CL_NONE, 0, 32'h0),
            mk_exp(32'h1, 0, 0, 0, 0, 0, 32'h0, 0, 4'b0000, 32'h0));
    add_vec(mk_op(32'h0, 32'h108, 32'h0055, 32'h0, 5'd0, CL_NONE, 0, 32'h0),
            mk_exp(32'h55, 0, 0, 0, 0, 0, 32'h0, 0, 4'b0000, 32'h0));
    add_vec(mk_op(32'h0000_9483, 32'h10C, 32'h6000, 32'h0, 5'd9, CL_LD, 2, 32'h0000_8001),
            mk_exp(32'hFFFF_8001, 1, 0, 0, 3, 3, 32'h6000, 0, 4'b0011, 32'h0));
    add_vec(mk_op(32'h0020_8023, 32'h110, 32'h7001, 32'h0000_00AA, 5'd0, CL_ST, 0, 32'h0),
            mk_exp(32'h7001, 0, 0, 0, 1, 1, 32'h7000, 1, 4'b0010, 32'hAAAA_AAAA));
    add_vec(mk_op(32'h0020_A023, 32'h114, 32'h8000, 32'hDEAD_BEEF, 5'd0, CL_ST, 0, 32'h0),
            mk_exp(32'h8000, 0, 0, 0, 1, 1, 32'h8000, 1, 4'b1111, 32'hDEAD_BEEF));
    add_vec(mk_op(32'h0000_C503, 32'h118, 32'h9001, 32'h0, 5'd10, CL_LD, 1, 32'h0000_F000),
            mk_exp(32'h0000_00F0, 1, 0, 0, 2, 2, 32'h9000, 0, 4'b0010, 32'h0));
    add_vec(mk_op(32'h0000_9483, 32'h11C, 32'h6001, 32'h0, 5'd9, CL_LD, 0, 32'h0),
            mk_exp(32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 4'b0000, 32'h0));
    add_vec(mk_op(32'h0000_A003, 32'h120, 32'hA000, 32'h0, 5'd0, CL_LD, 0, 32'h1234_5678),
            mk_exp(32'h1234_5678, 0, 0, 0, 1, 1, 32'hA000, 0, 4'b1111, 32'h0));
    add_vec(mk_op(32'h0000_80E7, 32'h200, 32'h0300, 32'h0, 5'd1, CL_JALR, 0, 32'h0),
            mk_exp(32'h204, 1, 0, 0, 0, 0, 32'h0, 0, 4'b0000, 32'h0));
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp);
    end

    // Randomized ops, back to back, against the model
    for (int i = 0; i < 80; i++) begin
      gen_random(o);
      e = model(o);
      run_op($sformatf("rnd%0d", i), o, e);
    end

    // Reset in the middle of a bus access, then a late acknowledge
    ex_inst = 32'h0000_A583; ex_pc = 32'h300; ex_alu = 32'hB000; ex_rs2 = 32'h0;
    ex_rd = 5'd11; ex_ld = 1'b1; ex_st = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("midreset", "in_bus", 32'(dbus.DREQ), 32'd1);
    #2;
    RESN = 1'b0;
    #1;
    check_all_zero("midreset");
    ex_inst = 32'd0; ex_alu = 32'h77; ex_ld = 1'b0; ex_rd = 5'd0;
    dbus.DACK = 1'b1;
    dbus.DRDATA = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    RESN = 1'b1;
    @(negedge CLK);
    check("late_dack", "dreq", 32'(dbus.DREQ), 32'd0);
    check("late_dack", "hlt", 32'(mem_hlt), 32'd0);
    @(posedge CLK);
    #1;
    dbus.DACK = 1'b0;
    check("late_dack", "wb_data", wb_data, 32'h77);
    check("late_dack", "wb_wen", 32'(wb_wen), 32'd0);
    check("late_dack", "wb_fault", 32'(wb_fault), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
